// File: rtl/floo_vc_input_buffer.sv
// Receive side of a VC-assigned credit link: per-VC circular FIFOs, head outputs and credit return.
// Define FLOO_VC_CREDIT_SHORTCUT_EN for same-cycle (combinational) credit return instead of registered.
module floo_vc_input_buffer #(
  parameter int unsigned NumVC      = 4,
  parameter int unsigned NumVCWidth = NumVC > 1 ? $clog2(NumVC) : 1,
  parameter int unsigned Depth      = 3,
  parameter int unsigned DataWidth  = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       valid_i,
  input  logic [NumVCWidth-1:0]      vc_id_i,
  input  logic [DataWidth-1:0]       data_i,
  output logic [NumVC-1:0]           vc_valid_o,
  output logic [NumVC*DataWidth-1:0] vc_data_o,
  input  logic [NumVC-1:0]           vc_ready_i,
  output logic                       credit_v_o,
  output logic [NumVCWidth-1:0]      credit_id_o,
  output logic                       overflow_o
);

  localparam int unsigned PtrWidth = Depth > 1 ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(Depth + 1);

  localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(Depth - 1);
  localparam logic [PtrWidth-1:0] PtrOne  = PtrWidth'(1);
  localparam logic [CntWidth-1:0] CntFull = CntWidth'(Depth);
  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

  logic [NumVC-1:0]      pop_vec;
  logic [NumVC-1:0]      ovf_vec;
  logic [NumVCWidth-1:0] pop_id;
  logic                  overflow_q;

  assign pop_vec = vc_valid_o & vc_ready_i;

  for (genvar v = 0; v < NumVC; v++) begin : gen_vc
    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrWidth-1:0]  rptr_q;
    logic [PtrWidth-1:0]  wptr_q;
    logic [CntWidth-1:0]  count_q;
    logic                 sel;
    logic                 full;
    logic                 push;

    assign sel  = valid_i && (vc_id_i == NumVCWidth'(v));
    assign full = (count_q == CntFull);
    // A full VC still takes a push when its head leaves in the same cycle.
    assign push       = sel && (!full || pop_vec[v]);
    assign ovf_vec[v] = sel && full && !pop_vec[v];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rptr_q  <= '0;
        wptr_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          wptr_q <= (wptr_q == PtrLast) ? '0 : wptr_q + PtrOne;
        end
        if (pop_vec[v]) begin
          rptr_q <= (rptr_q == PtrLast) ? '0 : rptr_q + PtrOne;
        end
        if (push && !pop_vec[v]) begin
          count_q <= count_q + CntOne;
        end else if (!push && pop_vec[v]) begin
          count_q <= count_q - CntOne;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (push) begin
        mem_q[wptr_q] <= data_i;
      end
    end

    assign vc_valid_o[v]                         = (count_q != '0);
    assign vc_data_o[v*DataWidth +: DataWidth] = mem_q[rptr_q];
  end

  always_comb begin
    pop_id = '0;
    for (int unsigned v = 0; v < NumVC; v++) begin
      if (pop_vec[v]) begin
        pop_id = pop_id | NumVCWidth'(v);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_q <= 1'b0;
    end else if (|ovf_vec) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow_o = overflow_q;

`ifdef FLOO_VC_CREDIT_SHORTCUT_EN
  assign credit_v_o  = |pop_vec;
  assign credit_id_o = pop_id;
`else
  logic                  credit_v_q;
  logic [NumVCWidth-1:0] credit_id_q;

  // The id register only moves on a pop so it holds the last credited VC.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      credit_v_q  <= 1'b0;
      credit_id_q <= '0;
    end else begin
      credit_v_q <= |pop_vec;
      if (|pop_vec) begin
        credit_id_q <= pop_id;
      end
    end
  end

  assign credit_v_o  = credit_v_q;
  assign credit_id_o = credit_id_q;
`endif

  ready_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(vc_ready_i));

endmodule

// File: tb/tb_floo_vc_input_buffer.sv
// Self-checking bench for floo_vc_input_buffer: directed vector table, hand sequences and a
// randomized phase, all compared against a queue-based reference model.
module tb_floo_vc_input_buffer;

  localparam int NumVC = 4;
  localparam int Depth = 3;
  localparam int DW    = 64;

  typedef logic [DW-1:0] flit_t;

  typedef struct {
    logic       valid;
    logic [1:0] vc;
    flit_t      data;
    logic [3:0] ready;
    logic [3:0] exp_valid;
    logic [1:0] head_vc;
    flit_t      exp_head;
    logic       exp_ovf;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_i;
  logic [1:0]        vc_id_i;
  flit_t             data_i;
  logic [NumVC-1:0]  vc_valid_o;
  logic [NumVC*DW-1:0] vc_data_o;
  logic [NumVC-1:0]  vc_ready_i;
  logic              credit_v_o;
  logic [1:0]        credit_id_o;
  logic              overflow_o;

  int checks = 0;
  int errors = 0;

  flit_t      mq [NumVC][$];
  logic       m_ovf;
  logic       m_cred_v;
  logic [1:0] m_cred_id;
  int         exp_credits;
  int         dut_credits;

  vec_t vecs [17];

  always #5 clk = ~clk;

  floo_vc_input_buffer #(
    .NumVC     (NumVC),
    .NumVCWidth(2),
    .Depth     (Depth),
    .DataWidth (DW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .valid_i    (valid_i),
    .vc_id_i    (vc_id_i),
    .data_i     (data_i),
    .vc_valid_o (vc_valid_o),
    .vc_data_o  (vc_data_o),
    .vc_ready_i (vc_ready_i),
    .credit_v_o (credit_v_o),
    .credit_id_o(credit_id_o),
    .overflow_o (overflow_o)
  );

  task automatic compareValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < NumVC; c++) mq[c].delete();
    m_ovf     = 1'b0;
    m_cred_v  = 1'b0;
    m_cred_id = 2'd0;
  endtask

  // Model rule: a pop frees its slot before the same-cycle push is judged for room.
  task automatic modelStep(input logic v, input logic [1:0] id, input flit_t d, input logic [3:0] r);
    logic       popped = 1'b0;
    logic [1:0] pid    = 2'd0;
    for (int c = 0; c < NumVC; c++) begin
      if (r[c] && mq[c].size() > 0) begin
        void'(mq[c].pop_front());
        popped = 1'b1;
        pid    = 2'(c);
      end
    end
    if (v) begin
      if (mq[id].size() < Depth) mq[id].push_back(d);
      else m_ovf = 1'b1;
    end
    if (popped) exp_credits++;
    m_cred_v = popped;
    if (popped) m_cred_id = pid;
  endtask

  task automatic checkOutput();
    logic [3:0] ev;
    logic       ecv;
    logic [1:0] eci;
    for (int c = 0; c < NumVC; c++) ev[c] = (mq[c].size() != 0);
    compareValue("vc_valid", 64'(vc_valid_o), 64'(ev));
    for (int c = 0; c < NumVC; c++) begin
      if (ev[c]) compareValue($sformatf("head_vc%0d", c), vc_data_o[c*DW +: DW], mq[c][0]);
    end
    compareValue("overflow", 64'(overflow_o), 64'(m_ovf));
`ifdef FLOO_VC_CREDIT_SHORTCUT_EN
    ecv = 1'b0;
    eci = 2'd0;
    for (int c = 0; c < NumVC; c++) begin
      if (vc_ready_i[c] && ev[c]) begin
        ecv = 1'b1;
        eci = 2'(c);
      end
    end
`else
    ecv = m_cred_v;
    eci = m_cred_id;
`endif
    compareValue("credit_v", 64'(credit_v_o), 64'(ecv));
    compareValue("credit_id", 64'(credit_id_o), 64'(eci));
    if (credit_v_o === 1'b1) dut_credits++;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] id, input flit_t d, input logic [3:0] r);
    @(negedge clk);
    valid_i    = v;
    vc_id_i    = id;
    data_i     = d;
    vc_ready_i = r;
    #1;
  endtask

  task automatic finishCycle();
    @(posedge clk);
    modelStep(valid_i, vc_id_i, data_i, vc_ready_i);
  endtask

  task automatic runCycle(input logic v, input logic [1:0] id, input flit_t d, input logic [3:0] r);
    applyStimulus(v, id, d, r);
    checkOutput();
    finishCycle();
  endtask

  task automatic resetAndCheck();
    @(negedge clk);
    rst        = 1'b1;
    valid_i    = 1'b0;
    vc_id_i    = 2'd0;
    data_i     = '0;
    vc_ready_i = 4'd0;
    @(posedge clk);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    compareValue("rst_vc_valid", 64'(vc_valid_o), 64'd0);
    compareValue("rst_credit_v", 64'(credit_v_o), 64'd0);
    compareValue("rst_credit_id", 64'(credit_id_o), 64'd0);
    compareValue("rst_overflow", 64'(overflow_o), 64'd0);
    finishCycle();
  endtask

  function automatic vec_t mk(input logic v, input logic [1:0] id, input flit_t d, input logic [3:0] r,
                              input logic [3:0] ev, input logic [1:0] hv, input flit_t eh, input logic eo);
    vec_t t;
    t.valid = v; t.vc = id; t.data = d; t.ready = r;
    t.exp_valid = ev; t.head_vc = hv; t.exp_head = eh; t.exp_ovf = eo;
    return t;
  endfunction

  initial begin
    // Expectations in each row are what must be visible before that row's clock edge.
    vecs[0]  = mk(1, 2, 64'hA1, 4'b0000, 4'b0000, 2, 64'h0,  0);
    vecs[1]  = mk(1, 2, 64'hA2, 4'b0000, 4'b0100, 2, 64'hA1, 0);
    vecs[2]  = mk(1, 2, 64'hA3, 4'b0000, 4'b0100, 2, 64'hA1, 0);
    vecs[3]  = mk(0, 0, 64'h0,  4'b0000, 4'b0100, 2, 64'hA1, 0);
    vecs[4]  = mk(0, 0, 64'h0,  4'b0100, 4'b0100, 2, 64'hA1, 0);
    vecs[5]  = mk(0, 0, 64'h0,  4'b0100, 4'b0100, 2, 64'hA2, 0);
    vecs[6]  = mk(0, 0, 64'h0,  4'b0100, 4'b0100, 2, 64'hA3, 0);
    vecs[7]  = mk(1, 1, 64'hC1, 4'b0000, 4'b0000, 2, 64'h0,  0);
    vecs[8]  = mk(1, 1, 64'hC2, 4'b0000, 4'b0010, 1, 64'hC1, 0);
    vecs[9]  = mk(1, 1, 64'hC3, 4'b0000, 4'b0010, 1, 64'hC1, 0);
    vecs[10] = mk(1, 1, 64'hFF, 4'b0000, 4'b0010, 1, 64'hC1, 0);
    vecs[11] = mk(0, 0, 64'h0,  4'b0000, 4'b0010, 1, 64'hC1, 1);
    vecs[12] = mk(1, 1, 64'hB4, 4'b0010, 4'b0010, 1, 64'hC1, 1);
    vecs[13] = mk(0, 0, 64'h0,  4'b0010, 4'b0010, 1, 64'hC2, 1);
    vecs[14] = mk(0, 0, 64'h0,  4'b0010, 4'b0010, 1, 64'hC3, 1);
    vecs[15] = mk(0, 0, 64'h0,  4'b0010, 4'b0010, 1, 64'hB4, 1);
    vecs[16] = mk(0, 0, 64'h0,  4'b0000, 4'b0000, 1, 64'h0,  1);

    rst        = 1'b1;
    valid_i    = 1'b0;
    vc_id_i    = 2'd0;
    data_i     = '0;
    vc_ready_i = 4'd0;
    exp_credits = 0;
    dut_credits = 0;
    modelReset();
    repeat (2) @(posedge clk);
    resetAndCheck();

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].vc, vecs[i].data, vecs[i].ready);
      checkOutput();
      compareValue($sformatf("tbl%0d_valid", i), 64'(vc_valid_o), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid[vecs[i].head_vc])
        compareValue($sformatf("tbl%0d_head", i), vc_data_o[vecs[i].head_vc*DW +: DW], vecs[i].exp_head);
      compareValue($sformatf("tbl%0d_ovf", i), 64'(overflow_o), 64'(vecs[i].exp_ovf));
      finishCycle();
    end

    // VC3 drains continuously while VC0 fills; pointers wrap several times.
    exp_credits = 0;
    dut_credits = 0;
    for (int i = 0; i < 10; i++) begin
      runCycle(1'b1, (i % 4 == 1) ? 2'd0 : 2'd3, 64'hD0 + 64'(i), 4'b1000);
    end
    runCycle(1'b1, 2'd3, 64'hE0, 4'b0000);
    runCycle(1'b0, 2'd0, 64'h0, 4'b0000);
    compareValue("wrap_credit_count", 64'(dut_credits), 64'(exp_credits));
    compareValue("vc0_full_valid", 64'(vc_valid_o[0]), 64'd1);

    resetAndCheck();
    applyStimulus(1'b1, 2'd0, 64'h11, 4'b0000);
    checkOutput();
    finishCycle();
    applyStimulus(1'b0, 2'd0, 64'h0, 4'b0000);
    compareValue("cold_vc_valid", 64'(vc_valid_o), 64'b0001);
    compareValue("cold_head_vc0", vc_data_o[0 +: DW], 64'h11);
    checkOutput();
    finishCycle();

    exp_credits = 0;
    dut_credits = 0;
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      r = ($urandom_range(0, 2) == 0) ? 4'b0000 : (4'b0001 << $urandom_range(0, 3));
      runCycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), {$urandom, $urandom}, r);
    end
    runCycle(1'b0, 2'd0, 64'h0, 4'b0000);
    runCycle(1'b0, 2'd0, 64'h0, 4'b0000);
    compareValue("rand_credit_count", 64'(dut_credits), 64'(exp_credits));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
